// File: rtl/load_store_unit.sv
// Load/store front end for the word-wide Data_Memory.
// Sub-word stores use read-modify-write; misaligned requests never reach memory.
module load_store_unit #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_misaligned,
  output logic [ADDR_W-3:0] MemAddr,
  output logic [DATA_W-1:0] Write_Data,
  output logic              MemRead,
  output logic              MemWrite,
  input  logic [DATA_W-1:0] Read_Data
);

  typedef enum logic [2:0] {
    IDLE, RD, WR, RESP, ERR
  } state_e;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  state_e              state_q, state_d;
  logic                write_q, write_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   wr_word_q, wr_word_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                accept;
  logic                misaligned;

  function automatic logic [31:0] extract(
    input logic [31:0] w,
    input logic [1:0]  sz,
    input logic [1:0]  a,
    input logic        uns
  );
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    unique case (1'b1)
      (sz == SZ_B): extract = uns ? {24'h0, b} : {{24{b[7]}}, b};
      (sz == SZ_H): extract = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default:      extract = w;
    endcase
  endfunction

  function automatic logic [31:0] merge(
    input logic [31:0] w,
    input logic [31:0] d,
    input logic [1:0]  sz,
    input logic [1:0]  a
  );
    merge = w;
    unique case (1'b1)
      (sz == SZ_B): merge[{a, 3'b000} +: 8] = d[7:0];
      (sz == SZ_H): begin
        if (a[1]) merge[31:16] = d[15:0];
        else      merge[15:0]  = d[15:0];
      end
      default:      merge = d;
    endcase
  endfunction

  assign req_ready = (state_q == IDLE) && !reset;
  assign accept    = req_valid && req_ready;

  always_comb begin
    misaligned = 1'b0;
    unique case (1'b1)
      (req_size == SZ_H): misaligned = req_addr[0];
      (req_size == SZ_W): misaligned = |req_addr[1:0];
      (req_size == SZ_B): misaligned = 1'b0;
      default:            misaligned = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    write_d   = write_q;
    size_d    = size_q;
    uns_d     = uns_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wr_word_d = wr_word_q;
    rdata_d   = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          write_d = req_write;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (misaligned) begin
            state_d = ERR;
          end else if (req_write && req_size == SZ_W) begin
            wr_word_d = req_wdata;
            state_d   = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: begin
        if (write_q) begin
          wr_word_d = merge(Read_Data, wdata_q, size_q, addr_q[1:0]);
          state_d   = WR;
        end else begin
          rdata_d = extract(Read_Data, size_q, addr_q[1:0], uns_q);
          state_d = RESP;
        end
      end
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      write_q   <= 1'b0;
      size_q    <= 2'b00;
      uns_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_word_q <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      write_q   <= write_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wr_word_q <= wr_word_d;
      rdata_q   <= rdata_d;
    end
  end

  // Enables are gated by reset so a reset edge can never commit a write.
  assign MemRead         = (state_q == RD) && !reset;
  assign MemWrite        = (state_q == WR) && !reset;
  assign MemAddr         = addr_q[ADDR_W-1:2];
  assign Write_Data      = wr_word_q;
  assign resp_valid      = (state_q == RESP) || (state_q == ERR);
  assign resp_misaligned = (state_q == ERR);
  assign resp_rdata      = rdata_q;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
MEM-stage front end that sits directly upstream of Data_Memory and drives its MemAddr/Write_Data/MemRead/MemWrite port.
- Accepts one byte-addressed load/store request at a time from the EX/MEM side via a valid/ready handshake.
- Translates byte/half/word accesses onto the 32-bit word-wide Data_Memory; sub-word stores are done by read-modify-write.
- Returns sign- or zero-extended load data with a one-cycle response pulse, and flags misaligned accesses without touching memory.

Parameters:
ADDR_W, 10, byte address width; word index is req_addr[ADDR_W-1:2], giving the 8-bit MemAddr.
DATA_W, 32, data width; fixed at 32, no other value supported.

Ports:
clk  in  1  single clock, rising edge
reset  in  1  synchronous, active-high
req_valid  in  1  request present
req_ready  out  1  LSU can accept a request this cycle
req_write  in  1  1=store, 0=load
req_size  in  2  00=byte, 01=half, 10=word, 11=illegal
req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
req_addr  in  10  byte address
req_wdata  in  32  store data, right-aligned
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  extended load result
resp_misaligned  out  1  qualifies resp_valid: access rejected
MemAddr  out  8  word address to Data_Memory
Write_Data  out  32  write word to Data_Memory
MemRead  out  1  read enable; Data_Memory Read_Data is combinational from MemAddr while MemRead=1
MemWrite  out  1  write enable; Data_Memory writes on the rising edge
Read_Data  in  32  word returned by Data_Memory

Behaviour:
- FSM states: IDLE, RD, WR, RESP, ERR.
- req_ready=1 only in IDLE and not reset.
- Accept = req_valid & req_ready. On accept, latch write, size, unsigned, addr and wdata.
- Decode on accept:
  - Misaligned (half with addr[0]=1, word with addr[1:0]!=0, or size 11) -> ERR.
  - Load -> RD.
  - Word store -> WR.
  - Sub-word store -> RD.
- RD state: MemRead=1, MemAddr=latched addr[9:2].
  - Load: Read_Data is lane-extracted and extended, registered into resp_rdata at the end of the cycle, then -> RESP.
  - Sub-word store: Read_Data is captured as the old word, then -> WR.
- WR state: MemWrite=1, MemAddr=latched word address, Write_Data as below, then -> RESP.
  - Word store: Write_Data = wdata.
  - Sub-word store: Write_Data = old word with the target lane replaced by wdata[7:0] or wdata[15:0].
- RESP state: resp_valid=1, resp_misaligned=0, then -> IDLE.
- ERR state: resp_valid=1, resp_misaligned=1, no MemRead/MemWrite, then -> IDLE.
- Lane mapping is little-endian.
  - Byte lane n = bits [8n+7:8n], n = addr[1:0].
  - Half: addr[1]=0 -> [15:0], addr[1]=1 -> [31:16].
- Latency from accept cycle T:
  - Load: resp_valid at T+2.
  - Word store: resp_valid at T+2.
  - Sub-word store: resp_valid at T+3.
  - Misaligned: resp_valid at T+1.
- Throughput: at most one request per latency+1 cycles, since a new accept only happens in IDLE.
- resp_valid has no backpressure and is high for exactly one cycle per accepted request.
- resp_rdata is updated only by loads; it holds its value across stores, misaligned responses and idle cycles.
- MemRead and MemWrite are never high together and are 0 outside RD and WR.
- MemAddr and Write_Data are driven from latched registers and are stable for the whole RD/WR cycle.
- req_valid held high while req_ready=0 is ignored; it is accepted on the first IDLE cycle.
- Reset values: state=IDLE, all latches=0, resp_rdata=0, MemAddr=0, Write_Data=0, MemRead=0, MemWrite=0, resp_valid=0, resp_misaligned=0, req_ready=0 during the reset cycle.
- Reset mid-operation: MemRead and MemWrite are gated by ~reset combinationally, so no memory write occurs on a reset edge. The FSM returns to IDLE, the in-flight request is dropped, and no response is issued.

Test Plan:
- Reset for 3 cycles, then release -> all outputs 0; req_ready=1 on the first cycle after reset deasserts.
- Word store 0xDEADBEEF @0x100, then word load @0x100 -> MemAddr=0x40, MemWrite pulses 1 cycle, resp_rdata=0xDEADBEEF at T+2.
- Byte store 0x80 @0x201 over word 0x11223344, then byte load @0x201 signed and unsigned -> memory word 0x11228044; loads return 0xFFFFFF80 and 0x00000080.
- Half store 0xA5A5 @0x102 over 0xDEADBEEF, then half load unsigned @0x102 -> memory word 0xA5A5BEEF; resp_rdata=0x0000A5A5; resp_valid at T+3 for the store.
- Word load @0x102, half load @0x081, and size 11 -> resp_valid with resp_misaligned=1 at T+1; MemRead=MemWrite=0; resp_rdata unchanged.
- Assert reset during the WR cycle of a byte store -> MemWrite stays 0, no resp_valid, target word unchanged, next request accepted normally.
